// File: rtl/rv32i_types.sv
// Shared types for the branch-predictor update path.
// Holds the update-controller state encoding, the queued update record and the PHT counter rule.
package rv32i_types;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } bp_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } bp_upd_t;

    localparam logic [1:0] PHT_INIT = 2'b01;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] pht_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken && cur != 2'b11) begin
            nxt = cur + 2'b01;
        end else if (!taken && cur != 2'b00) begin
            nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue: circular buffer with synchronous clear, head visible combinationally.
// Latency: an entry pushed at an edge is at the head after that edge.
// Backpressure: full is raised at DEPTH entries; pushes while full and pops while empty are ignored.
module bp_upd_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty,
    output logic         one_left
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign one_left = (count == (AW+1)'(1));
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: queues resolved branches, read-modify-writes PHT/BTB, owns the BHR.
// Latency: one update per READ+WRITE pair (2 cycles); table sweep takes 2^S_IDX cycles.
// Backpressure: upd_ready drops when the queue is full or on the cycle a flush is taken.
module bp_update_ctrl
    import rv32i_types::*;
#(
    parameter int S_IDX   = 2,
    parameter int Q_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_taken,
    input  logic             flush_req,
    output logic             busy,
    output logic [S_IDX-1:0] bhr,
    output logic [S_IDX-1:0] tbl_rindex,
    input  logic [1:0]       tbl_rdata_pht,
    input  logic [31:0]      tbl_rdata_btb,
    output logic             tbl_we,
    output logic [S_IDX-1:0] tbl_windex,
    output logic [1:0]       tbl_wdata_pht,
    output logic [31:0]      tbl_wdata_btb
);

    localparam logic [S_IDX-1:0] SWEEP_LAST = '1;

    bp_state_t        state;
    bp_state_t        state_nxt;
    logic [S_IDX-1:0] sweep;
    logic [S_IDX-1:0] cap_idx;
    logic [1:0]       cap_pht;
    logic [31:0]      cap_btb;
    logic             flush_pend;
    logic             flush_any;
    logic             flush_take;
    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic             q_one_left;
    logic             q_more;
    bp_upd_t          in_rec;
    bp_upd_t          head;
    logic             unused_pc_bits;

    assign in_rec = '{pc: upd_pc, target: upd_target, taken: upd_taken};

    bp_upd_fifo #(
        .W     ($bits(bp_upd_t)),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush_take),
        .push     (q_push),
        .push_dat (in_rec),
        .pop      (q_pop),
        .pop_dat  (head),
        .full     (q_full),
        .empty    (q_empty),
        .one_left (q_one_left)
    );

    assign unused_pc_bits = ^head.pc[31:S_IDX];

    assign flush_any  = flush_req || flush_pend;
    assign upd_ready  = rst && !q_full && !flush_take;
    assign q_push     = upd_valid && upd_ready;
    assign q_more     = !q_one_left || q_push;
    assign busy       = (state != IDLE) || !q_empty;
    assign tbl_rindex = head.pc[S_IDX-1:0] ^ bhr;

    // A flush while already sweeping restarts the sweep instead of waiting.
    always_comb begin
        flush_take = 1'b0;
        state_nxt  = state;
        case (state)
            INIT: begin
                flush_take = flush_req;
                if (flush_req)                 state_nxt = INIT;
                else if (sweep == SWEEP_LAST)  state_nxt = IDLE;
            end
            IDLE: begin
                flush_take = flush_any;
                if (flush_any)     state_nxt = INIT;
                else if (!q_empty) state_nxt = READ;
            end
            READ: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                flush_take = flush_any;
                if (flush_any)   state_nxt = INIT;
                else if (q_more) state_nxt = READ;
                else             state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        tbl_we        = 1'b0;
        tbl_windex    = cap_idx;
        tbl_wdata_pht = pht_next(cap_pht, head.taken);
        tbl_wdata_btb = head.taken ? head.target : cap_btb;
        q_pop         = 1'b0;
        case (state)
            INIT: begin
                tbl_we        = rst;
                tbl_windex    = sweep;
                tbl_wdata_pht = PHT_INIT;
                tbl_wdata_btb = '0;
            end
            WRITE: begin
                tbl_we = rst;
                q_pop  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep      <= '0;
            bhr        <= '0;
            flush_pend <= 1'b0;
            cap_idx    <= '0;
            cap_pht    <= '0;
            cap_btb    <= '0;
        end else begin
            if (flush_take) begin
                sweep <= '0;
            end else if (state == INIT) begin
                sweep <= sweep + 1'b1;
            end

            if (flush_take) begin
                bhr <= '0;
            end else if (state == WRITE) begin
                bhr <= {bhr[S_IDX-2:0], head.taken};
            end

            if (flush_take) begin
                flush_pend <= 1'b0;
            end else if (flush_req && state != IDLE) begin
                flush_pend <= 1'b1;
            end

            if (state == READ) begin
                cap_idx <= tbl_rindex;
                cap_pht <= tbl_rdata_pht;
                cap_btb <= tbl_rdata_btb;
            end
        end
    end

endmodule
